// File: rtl/ram_multiport_pkg.sv
// Shared constants for the multi-port RAM: enable/direction encodings and
// the address-width helper used by the top and the read-port slice.
package ram_multiport_pkg;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic READ    = 1'b1;
    localparam logic WRITE   = 1'b0;
    localparam logic LOW     = 1'b0;
    localparam logic HIGH    = 1'b1;

    // A single-word RAM still needs a one-bit address port.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_multiport_rport.sv
// One read port: range-checked word mux, plus an optional output register
// that loads only on an enabled read request and otherwise holds.
module ram_multiport_rport
    import ram_multiport_pkg::*;
#(
    parameter int DATA   = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR   = 2,
    parameter int OUTREG = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rd_en,
    input  logic [ADDR-1:0]            addr,
    input  logic                       addr_ok,
    input  logic [DEPTH-1:0][DATA-1:0] mem,
    output logic [DATA-1:0]            rdata
);

    logic [DATA-1:0] mux_data;
    logic [DATA-1:0] rdata_d;
    logic [DATA-1:0] rdata_q;

    always_comb begin
        mux_data = '0;
        if (addr_ok) begin
            mux_data = mem[addr];
        end
    end

    // mem is the pre-edge array, so a same-cycle write is not seen here (read-first).
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mux_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    generate
        if (OUTREG != 0) begin : g_reg_out
            assign rdata = rdata_q;
        end else begin : g_comb_out
            assign rdata = mux_data;
        end
    endgenerate

endmodule

// File: rtl/ram_multiport.sv
// Flop-based RAM with PORT independent read/write ports over one array.
// Simultaneous writes to one word resolve to the highest-index port.
module ram_multiport
    import ram_multiport_pkg::*;
#(
    parameter int DATA   = 32,
    parameter int DEPTH  = 4,
    parameter int PORT   = 2,
    parameter int OUTREG = 0,
    localparam int ADDR  = addr_bits(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PORT-1:0]           en,
    input  logic [PORT-1:0]           rw_,
    input  logic [PORT-1:0][ADDR-1:0] addr,
    input  logic [PORT-1:0][DATA-1:0] wdata,
    output logic [PORT-1:0][DATA-1:0] rdata
);

    localparam logic [ADDR:0] DEPTH_W = (ADDR + 1)'(DEPTH);

    logic [DEPTH-1:0][DATA-1:0] mem_d;
    logic [DEPTH-1:0][DATA-1:0] mem_q;
    logic [PORT-1:0]            addr_ok;
    logic [PORT-1:0]            rd_req;

    genvar gi;
    generate
        for (gi = 0; gi < PORT; gi++) begin : g_port_dec
            assign addr_ok[gi] = ({1'b0, addr[gi]} < DEPTH_W);
            assign rd_req[gi]  = (en[gi] == ENABLE) && (rw_[gi] == READ);
        end
    endgenerate

    // Ascending loop: a later (higher) port overwrites an earlier one on the same word.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < PORT; p++) begin
            if ((en[p] == ENABLE) && (rw_[p] == WRITE) && addr_ok[p]) begin
                mem_d[addr[p]] = wdata[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    generate
        for (gi = 0; gi < PORT; gi++) begin : g_rport
            ram_multiport_rport #(
                .DATA   (DATA),
                .DEPTH  (DEPTH),
                .ADDR   (ADDR),
                .OUTREG (OUTREG)
            ) u_rport (
                .clk     (clk),
                .reset   (reset),
                .rd_en   (rd_req[gi]),
                .addr    (addr[gi]),
                .addr_ok (addr_ok[gi]),
                .mem     (mem_q),
                .rdata   (rdata[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ram_multiport.sv
// Directed bench: one combinational-output and one registered-output RAM
// (DEPTH=5, so addresses 5..7 are out of range) driven with identical stimulus.
module tb_ram_multiport;

    localparam int DATA  = 32;
    localparam int DEPTH = 5;
    localparam int PORT  = 2;
    localparam int AW    = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [PORT-1:0]         en;
    logic [PORT-1:0]         rw;
    logic [PORT-1:0][AW-1:0] addr;
    logic [PORT-1:0][DATA-1:0] wdata;
    logic [PORT-1:0][DATA-1:0] rdata_c;
    logic [PORT-1:0][DATA-1:0] rdata_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_multiport #(.DATA(DATA), .DEPTH(DEPTH), .PORT(PORT), .OUTREG(0)) u_comb (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .rw_   (rw),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata_c)
    );

    ram_multiport #(.DATA(DATA), .DEPTH(DEPTH), .PORT(PORT), .OUTREG(1)) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .rw_   (rw),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata_r)
    );

    typedef struct {
        logic          rst;
        logic          en0;
        logic          rw0;
        logic [AW-1:0] a0;
        logic [31:0]   w0;
        logic          en1;
        logic          rw1;
        logic [AW-1:0] a1;
        logic [31:0]   w1;
        logic [31:0]   c0;
        logic [31:0]   c1;
        logic [31:0]   r0;
        logic [31:0]   r1;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic rst,
                        input logic e0, input logic d0, input logic [AW-1:0] a0, input logic [31:0] w0,
                        input logic e1, input logic d1, input logic [AW-1:0] a1, input logic [31:0] w1,
                        input logic [31:0] c0, input logic [31:0] c1,
                        input logic [31:0] r0, input logic [31:0] r1);
        vec_t v;
        v.rst = rst; v.en0 = e0; v.rw0 = d0; v.a0 = a0; v.w0 = w0;
        v.en1 = e1; v.rw1 = d1; v.a1 = a1; v.w1 = w1;
        v.c0 = c0; v.c1 = c1; v.r0 = r0; v.r1 = r1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        en    = '0;
        rw    = '1;
        addr  = '0;
        wdata = '0;

        //   rst  en0 rw0 a0 w0            en1 rw1 a1 w1            comb0         comb1         reg0          reg1
        addv(1, 0, 1, 0, 32'h0,         0, 1, 0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0);
        addv(0, 1, 0, 0, 32'hdaedbeef,  0, 1, 0, 32'h0,         32'hdaedbeef, 32'hdaedbeef, 32'h0,        32'h0);
        addv(0, 0, 1, 1, 32'h0,         1, 1, 0, 32'h0,         32'h0,        32'hdaedbeef, 32'h0,        32'hdaedbeef);
        addv(0, 0, 1, 1, 32'h0,         0, 1, 3, 32'h0,         32'h0,        32'h0,        32'h0,        32'hdaedbeef);
        addv(0, 1, 0, 2, 32'h11111111,  1, 0, 2, 32'h22222222,  32'h22222222, 32'h22222222, 32'h0,        32'hdaedbeef);
        addv(0, 1, 1, 2, 32'h0,         1, 1, 0, 32'h0,         32'h22222222, 32'hdaedbeef, 32'h22222222, 32'hdaedbeef);
        addv(0, 1, 0, 1, 32'ha,         1, 0, 4, 32'h44444444,  32'ha,        32'h44444444, 32'h22222222, 32'hdaedbeef);
        addv(0, 1, 0, 1, 32'hb,         1, 1, 1, 32'h0,         32'hb,        32'hb,        32'h22222222, 32'ha);
        addv(0, 0, 1, 1, 32'h0,         1, 1, 1, 32'h0,         32'hb,        32'hb,        32'h22222222, 32'hb);
        addv(0, 1, 0, 5, 32'hdeadbeef,  1, 1, 7, 32'h0,         32'h0,        32'h0,        32'h22222222, 32'h0);
        addv(0, 1, 1, 0, 32'h0,         1, 1, 1, 32'h0,         32'hdaedbeef, 32'hb,        32'hdaedbeef, 32'hb);
        addv(0, 1, 1, 3, 32'h0,         1, 1, 4, 32'h0,         32'h0,        32'h44444444, 32'h0,        32'h44444444);
        addv(0, 1, 1, 2, 32'h0,         1, 1, 5, 32'h0,         32'h22222222, 32'h0,        32'h22222222, 32'h0);
        addv(0, 1, 0, 3, 32'h5,         0, 1, 3, 32'h0,         32'h5,        32'h5,        32'h22222222, 32'h0);
        addv(1, 1, 0, 3, 32'h7,         1, 1, 3, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0);
        addv(0, 1, 1, 3, 32'h0,         1, 1, 0, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0);
        addv(0, 1, 1, 1, 32'h0,         1, 1, 4, 32'h0,         32'h0,        32'h0,        32'h0,        32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            en[0]    = vecs[i].en0;
            rw[0]    = vecs[i].rw0;
            addr[0]  = vecs[i].a0;
            wdata[0] = vecs[i].w0;
            en[1]    = vecs[i].en1;
            rw[1]    = vecs[i].rw1;
            addr[1]  = vecs[i].a1;
            wdata[1] = vecs[i].w1;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_comb_p0", i), rdata_c[0], vecs[i].c0);
            chk($sformatf("v%0d_comb_p1", i), rdata_c[1], vecs[i].c1);
            chk($sformatf("v%0d_reg_p0", i),  rdata_r[0], vecs[i].r0);
            chk($sformatf("v%0d_reg_p1", i),  rdata_r[1], vecs[i].r1);
            $display("vec %0d rst=%0b en=%b rw=%b a0=%0d a1=%0d comb=%h/%h reg=%h/%h",
                     i, vecs[i].rst, en, rw, addr[0], addr[1],
                     rdata_c[0], rdata_c[1], rdata_r[0], rdata_r[1]);
        end

        // Write visibility timing on the combinational port, and mux response without a clock.
        @(negedge clk);
        reset = 1'b0;
        en = 2'b01; rw = 2'b10;
        addr[0] = 3'd2; wdata[0] = 32'h12345678;
        addr[1] = 3'd2; wdata[1] = 32'h0;
        #1;
        chk("seq_comb_before_edge", rdata_c[1], 32'h0);
        @(posedge clk);
        #1;
        chk("seq_comb_after_edge", rdata_c[1], 32'h12345678);
        chk("seq_reg_no_read_hold", rdata_r[1], 32'h0);
        @(negedge clk);
        en = 2'b00;
        addr[1] = 3'd0;
        #1;
        chk("seq_comb_addr_change_0", rdata_c[1], 32'h0);
        addr[1] = 3'd2;
        #1;
        chk("seq_comb_addr_change_2", rdata_c[1], 32'h12345678);
        chk("seq_reg_still_held", rdata_r[1], 32'h0);
        en = 2'b10; rw = 2'b11;
        @(posedge clk);
        #1;
        chk("seq_reg_read_latency", rdata_r[1], 32'h12345678);
        $display("seq comb=%h reg=%h", rdata_c[1], rdata_r[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
